frame_loader_bram0: RTL and testbench



---
 rtl/frame_loader_bram0.sv | 151 +++++++++++++++
 tb/tb_frame_loader_bram0.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader_bram0.sv
// rtl/frame_loader_bram0.sv - frame ingest into BRAM0 port 0 with Sobel FSM handoff
`timescale 1ns/1ps

module frame_loader_bram0 #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pix_valid,
  input  logic [DATA_WIDTH-1:0] i_pix_data,
  input  logic                  i_sof,
  input  logic                  i_run_mode,
  output logic                  o_pix_ready,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic                  o_en,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_run,
  input  logic                  i_done,
  output logic                  o_idle,
  output logic                  o_load,
  output logic                  o_frame_err
);

  localparam int FRAME_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_SIZE - 1);

  generate
    if (64'(FRAME_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_size_check
      $error("FRAME_SIZE does not fit in the BRAM0 address space");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FLUSH   = 3'd2,
    S_HANDOFF = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    run_q, run_d;
  logic                    err_q, err_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ready_c;
  logic                    accept_c;

  // State and write-port registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next state, write counter and registered BRAM write request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    err_d    = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    ready_c  = (state_q == S_IDLE) || (state_q == S_LOAD);
    accept_c = i_pix_valid && ready_c;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (i_sof) begin
            we_d   = 1'b1;
            addr_d = '0;
            data_d = i_pix_data;
            run_d  = i_run_mode;
            if (FRAME_SIZE == 1) begin
              cnt_d   = '0;
              state_d = S_FLUSH;
            end else begin
              cnt_d   = ADDR_WIDTH'(1);
              state_d = S_LOAD;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept_c) begin
          we_d   = 1'b1;
          data_d = i_pix_data;
          if (i_sof) begin
            // A new SOF mid-frame restarts the frame, even on the final beat.
            addr_d = '0;
            cnt_d  = ADDR_WIDTH'(1);
            run_d  = i_run_mode;
            err_d  = 1'b1;
          end else begin
            addr_d = cnt_q;
            if (cnt_q == LAST_ADDR) begin
              cnt_d   = '0;
              state_d = S_FLUSH;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
      end
      S_FLUSH:   state_d = S_HANDOFF;
      S_HANDOFF: state_d = S_WAIT;
      S_WAIT: begin
        if (i_done) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  assign o_pix_ready = ready_c && !rst;
  assign b0_d0       = data_q;
  assign b0_ce0      = we_q;
  assign b0_we0      = we_q;
  assign b0_addr0    = addr_q;
  assign o_en        = (state_q == S_HANDOFF);
  assign o_num_cnt   = LAST_ADDR;
  assign o_run       = run_q;
  assign o_idle      = (state_q == S_IDLE);
  assign o_load      = (state_q == S_LOAD);
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_frame_loader_bram0.sv
// tb/tb_frame_loader_bram0.sv - scoreboard bench for frame_loader_bram0
`timescale 1ns/1ps

module tb_frame_loader_bram0;

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        sof;
  logic        run_mode;
  logic        pix_ready;
  logic [7:0]  b0_d0;
  logic        b0_ce0;
  logic        b0_we0;
  logic [11:0] b0_addr0;
  logic        en;
  logic [11:0] num_cnt;
  logic        run;
  logic        done;
  logic        idle;
  logic        load;
  logic        frame_err;

  frame_loader_bram0 #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pix_valid(pix_valid), .i_pix_data(pix_data), .i_sof(sof), .i_run_mode(run_mode),
    .o_pix_ready(pix_ready),
    .b0_d0(b0_d0), .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_addr0(b0_addr0),
    .o_en(en), .o_num_cnt(num_cnt), .o_run(run), .i_done(done),
    .o_idle(idle), .o_load(load), .o_frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_wr_cyc = -10;
  int          en_count = 0;
  int          err_count = 0;
  logic        exp_run = 1'b0;
  logic [19:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic m, input logic dn);
    @(posedge clk);
    #1;
    pix_valid = v;
    pix_data  = d;
    sof       = s;
    run_mode  = m;
    done      = dn;
  endtask

  task automatic send_frame(input logic [7:0] base, input bit toggle, input logic mode, input int flip_at);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, base + 8'(i), (i == 0), (i >= flip_at) ? ~mode : mode, 1'b0);
      chk("ready_on_beat", 32'(pix_ready), 32'd1);
      sb.push_back({12'(i), base + 8'(i)});
      if (toggle && i < 15) begin
        drive(1'b0, 8'h00, 1'b0, mode, 1'b0);
        chk("load_during_gap", 32'(load), 32'd1);
      end
    end
  endtask

  task automatic finish_frame();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("ready_after_frame", 32'(pix_ready), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("idle_after_done", 32'(idle), 32'd1);
    chk("ready_after_done", 32'(pix_ready), 32'd1);
  endtask

  // Write/handoff monitor: pops the scoreboard on each BRAM write.
  always @(negedge clk) begin
    logic [19:0] e;
    cyc++;
    if (!rst) begin
      chk("ce_eq_we", 32'(b0_ce0), 32'(b0_we0));
      if (b0_we0) begin
        if (sb.size() == 0) begin
          chk("write_without_beat", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(b0_addr0), 32'(e[19:8]));
          chk("wr_data", 32'(b0_d0), 32'(e[7:0]));
          last_wr_cyc = cyc;
        end
      end
      if (en) begin
        en_count++;
        chk("en_timing", cyc, last_wr_cyc + 1);
        chk("en_sb_empty", 32'(sb.size()), 32'd0);
        chk("num_cnt", 32'(num_cnt), 32'd15);
        chk("run_at_en", 32'(run), 32'(exp_run));
      end
      if (frame_err) err_count++;
      if (load) begin
        chk("ready_in_load", 32'(pix_ready), 32'd1);
        chk("run_hold", 32'(run), 32'(exp_run));
      end
      if (!idle && !load) chk("ready_off", 32'(pix_ready), 32'd0);
    end
  end

  initial begin
    int en0;
    int err0;
    rst = 1'b1; pix_valid = 1'b0; pix_data = 8'h00; sof = 1'b0; run_mode = 1'b0; done = 1'b0;
    #1;
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_we", 32'(b0_we0), 32'd0);
    chk("rst_addr", 32'(b0_addr0), 32'd0);
    chk("rst_data", 32'(b0_d0), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", 32'(pix_ready), 32'd1);

    // Back-to-back frame, run mode 1.
    exp_run = 1'b1;
    send_frame(8'h10, 1'b0, 1'b1, 16);
    finish_frame();
    chk("t1_en_count", en_count, 1);

    // Valid toggling every other cycle.
    send_frame(8'h10, 1'b1, 1'b1, 16);
    finish_frame();
    chk("t2_en_count", en_count, 2);

    // Valid held high through WAIT; early done (in FLUSH) must be ignored.
    send_frame(8'h40, 1'b0, 1'b1, 16);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 8'hEE, 1'b0, 1'b1, (k == 0));
      chk("t3_ready_wait", 32'(pix_ready), 32'd0);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_ready_back", 32'(pix_ready), 32'd1);
    chk("t3_en_count", en_count, 3);

    // Stray beats, partial frame, restart with 0xAA.
    err0 = err_count;
    for (int k = 0; k < 3; k++) drive(1'b1, 8'h55 + 8'(k), 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'h60 + 8'(k), (k == 0), 1'b1, 1'b0);
      sb.push_back({12'(k), 8'h60 + 8'(k)});
    end
    send_frame(8'hAA, 1'b0, 1'b1, 16);
    finish_frame();
    chk("t4_err_pulses", err_count - err0, 4);
    chk("t4_en_count", en_count, 4);

    // Reset mid-frame.
    exp_run = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 8'h70 + 8'(k), (k == 0), 1'b0, 1'b0);
      sb.push_back({12'(k), 8'h70 + 8'(k)});
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_ready", 32'(pix_ready), 32'd0);
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_load", 32'(load), 32'd0);
    chk("t5_we", 32'(b0_we0), 32'd0);
    chk("t5_addr", 32'(b0_addr0), 32'd0);
    chk("t5_data", 32'(b0_d0), 32'd0);
    chk("t5_run", 32'(run), 32'd0);
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);
    en0 = en_count;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_no_en", en_count, en0);
    exp_run = 1'b1;
    send_frame(8'h80, 1'b0, 1'b1, 16);
    finish_frame();
    chk("t5_en_count", en_count, en0 + 1);

    // Run mode 0 latched at SOF; later mode changes ignored.
    exp_run = 1'b0;
    send_frame(8'hC0, 1'b0, 1'b0, 8);
    chk("t6_run", 32'(run), 32'd0);
    finish_frame();
    chk("t6_en_count", en_count, en0 + 2);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
